mem_rd_arbiter: RTL and testbench

Shares the single read port of the on-chip feature/weight SRAM between the weight loader and the ifmap loader. The top-level sequencer drives both loaders at once while prefetching the next weight tile during convolution, so both can request in the same cycle. The block grants one read per cycle using burst-limited round-robin, then routes each read response back to its issuer after the fixed SRAM latency. It sits between the two loaders and the SRAM macro.

---
 rtl/acc_pkg.sv | 24 ++
 rtl/rd_tag_pipe.sv | 45 ++++
 rtl/mem_rd_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_rd_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared accelerator definitions for the SRAM read path.
// Holds the owner-state and requester-id enums used by the read arbiter,
// plus the default geometry shared with the loaders and the SRAM wrapper.
package acc_pkg;

  localparam int ACC_ADDR_W    = 16;
  localparam int ACC_DATA_W    = 64;
  localparam int ACC_RD_LAT    = 2;
  localparam int ACC_BURST_MAX = 8;

  // Which requester currently holds the SRAM read port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_W  = 2'd1,
    OWN_IF = 2'd2
  } owner_e;

  // Requester identity carried alongside each in-flight read.
  typedef enum logic {
    REQ_W  = 1'b0,
    REQ_IF = 1'b1
  } req_id_e;

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-deep shift register of {valid, id} tags that tracks
// reads in flight through the SRAM so each response can be steered to the
// requester that issued it.
// Ports:
//   clk, rst     clock, synchronous active-high clear (drops all tags)
//   i_push       a read was issued this cycle
//   i_push_id    requester that owns the issued read
//   o_valid      the tag leaving the last stage is a real read
//   o_id         requester owning that read
module rd_tag_pipe
  import acc_pkg::*;
#(
  parameter int DEPTH = ACC_RD_LAT
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_push,
  input  req_id_e i_push_id,
  output logic    o_valid,
  output req_id_e o_id
);

  logic [DEPTH-1:0] r_valid;
  req_id_e          r_id [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_id[i] <= REQ_W;
      end
    end else begin
      r_valid[0] <= i_push;
      r_id[0]    <= i_push_id;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_id[i]    <= r_id[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_id    = r_id[DEPTH-1];

endmodule

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: shares the single SRAM read port between the weight
// loader (W) and the ifmap loader (IF) with burst-limited round-robin, and
// routes each read response back to its issuer RD_LAT cycles later.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   w_req/w_addr/w_gnt          weight read request, address, issue strobe
//   w_rvalid/w_rdata            weight read response
//   if_req/if_addr/if_gnt       ifmap read request, address, issue strobe
//   if_rvalid/if_rdata          ifmap read response
//   mem_re/mem_addr/mem_rdata   SRAM read port
//   o_dbg_owner/o_dbg_burst_cnt registered owner state and burst count
//
// Handshake: a requester holds X_req high with a stable X_addr until it sees
// X_gnt high in the same cycle; that cycle the read is issued. X_gnt is
// combinational from the registered owner state and the current requests.
// The arbiter keeps no copy of an ungranted request. X_rvalid pulses for
// exactly one cycle per granted read, RD_LAT cycles after its grant, in
// issue order, and qualifies X_rdata.
module mem_rd_arbiter
  import acc_pkg::*;
#(
  parameter int  ADDR_W    = ACC_ADDR_W,
  parameter int  DATA_W    = ACC_DATA_W,
  parameter int  RD_LAT    = ACC_RD_LAT,
  parameter int  BURST_MAX = ACC_BURST_MAX,
  localparam int CNT_W     = $clog2(BURST_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  output logic              w_gnt,
  output logic              w_rvalid,
  output logic [DATA_W-1:0] w_rdata,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output owner_e            o_dbg_owner,
  output logic [CNT_W-1:0]  o_dbg_burst_cnt
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  owner_e           r_owner,     w_owner_nxt;
  logic [CNT_W-1:0] r_burst_cnt, w_burst_cnt_nxt;
  req_id_e          r_rr_next,   w_rr_next_nxt;

  logic    w_grant_w;
  logic    w_grant_if;
  logic    w_burst_open;
  logic    w_tag_valid;
  req_id_e w_tag_id;

  // The owner may keep going while under its burst limit; at the limit it
  // only continues if the other side is not waiting.
  assign w_burst_open = (r_burst_cnt < BURST_LIM);

  // Grant decision. Gated by rst so nothing is issued while in reset.
  always_comb begin
    w_grant_w  = 1'b0;
    w_grant_if = 1'b0;
    if (!rst) begin
      case (r_owner)
        OWN_W: begin
          if (w_req && (w_burst_open || !if_req)) w_grant_w  = 1'b1;
          else if (if_req)                        w_grant_if = 1'b1;
        end
        OWN_IF: begin
          if (if_req && (w_burst_open || !w_req)) w_grant_if = 1'b1;
          else if (w_req)                         w_grant_w  = 1'b1;
        end
        default: begin
          if (w_req && if_req) begin
            if (r_rr_next == REQ_W) w_grant_w  = 1'b1;
            else                    w_grant_if = 1'b1;
          end else if (w_req) begin
            w_grant_w = 1'b1;
          end else if (if_req) begin
            w_grant_if = 1'b1;
          end
        end
      endcase
    end
  end

  // Owner / burst / round-robin next state.
  always_comb begin
    w_owner_nxt     = IDLE;
    w_burst_cnt_nxt = '0;
    w_rr_next_nxt   = r_rr_next;
    if (w_grant_w) begin
      w_owner_nxt     = OWN_W;
      w_rr_next_nxt   = REQ_IF;
      if (r_owner == OWN_W)
        w_burst_cnt_nxt = (r_burst_cnt == BURST_LIM) ? BURST_LIM : r_burst_cnt + 1'b1;
      else
        w_burst_cnt_nxt = CNT_W'(1);
    end else if (w_grant_if) begin
      w_owner_nxt     = OWN_IF;
      w_rr_next_nxt   = REQ_W;
      if (r_owner == OWN_IF)
        w_burst_cnt_nxt = (r_burst_cnt == BURST_LIM) ? BURST_LIM : r_burst_cnt + 1'b1;
      else
        w_burst_cnt_nxt = CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= IDLE;
      r_burst_cnt <= '0;
      r_rr_next   <= REQ_W;
    end else begin
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_rr_next   <= w_rr_next_nxt;
    end
  end

  assign w_gnt    = w_grant_w;
  assign if_gnt   = w_grant_if;
  assign mem_re   = w_grant_w | w_grant_if;
  assign mem_addr = w_grant_w  ? w_addr  :
                    w_grant_if ? if_addr : '0;

  rd_tag_pipe #(
    .DEPTH(RD_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .i_push   (mem_re),
    .i_push_id(w_grant_if ? REQ_IF : REQ_W),
    .o_valid  (w_tag_valid),
    .o_id     (w_tag_id)
  );

  // Masking with rst covers the reset cycle itself, before the synchronous
  // clear has emptied the tag pipe.
  assign w_rvalid  = !rst && w_tag_valid && (w_tag_id == REQ_W);
  assign if_rvalid = !rst && w_tag_valid && (w_tag_id == REQ_IF);
  assign w_rdata   = mem_rdata;
  assign if_rdata  = mem_rdata;

  assign o_dbg_owner     = r_owner;
  assign o_dbg_burst_cnt = r_burst_cnt;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Bench for mem_rd_arbiter: instance a (RD_LAT=2, BURST_MAX=4) and
// instance b (RD_LAT=1, BURST_MAX=1), each with a small SRAM model that
// returns a word derived from the read address.
module tb_mem_rd_arbiter;
  import acc_pkg::*;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance a ----------------
  logic        rst, w_req, if_req, w_gnt, if_gnt, w_rvalid, if_rvalid, mem_re;
  logic [15:0] w_addr, if_addr, mem_addr;
  logic [63:0] w_rdata, if_rdata, mem_rdata;
  owner_e      dbg_owner;
  logic [2:0]  dbg_cnt;

  mem_rd_arbiter #(.ADDR_W(16), .DATA_W(64), .RD_LAT(2), .BURST_MAX(4)) dut_a (
    .clk(clk), .rst(rst),
    .w_req(w_req), .w_addr(w_addr), .w_gnt(w_gnt), .w_rvalid(w_rvalid), .w_rdata(w_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .o_dbg_owner(dbg_owner), .o_dbg_burst_cnt(dbg_cnt)
  );

  // ---------------- instance b ----------------
  logic        rst_b, w_req_b, if_req_b, w_gnt_b, if_gnt_b, w_rvalid_b, if_rvalid_b, mem_re_b;
  logic [15:0] w_addr_b, if_addr_b, mem_addr_b;
  logic [63:0] w_rdata_b, if_rdata_b, mem_rdata_b;
  owner_e      dbg_owner_b;
  logic [0:0]  dbg_cnt_b;

  mem_rd_arbiter #(.ADDR_W(16), .DATA_W(64), .RD_LAT(1), .BURST_MAX(1)) dut_b (
    .clk(clk), .rst(rst_b),
    .w_req(w_req_b), .w_addr(w_addr_b), .w_gnt(w_gnt_b), .w_rvalid(w_rvalid_b), .w_rdata(w_rdata_b),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
    .mem_re(mem_re_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
    .o_dbg_owner(dbg_owner_b), .o_dbg_burst_cnt(dbg_cnt_b)
  );

  // ---------------- SRAM models ----------------
  function automatic logic [63:0] sram_word(input logic [15:0] a);
    return {~a, 16'hC0DE, a ^ 16'h5A5A, a};
  endfunction

  logic [15:0] sa0, sa1, sb0;
  always @(posedge clk) begin
    sa0 <= mem_addr;
    sa1 <= sa0;
    sb0 <= mem_addr_b;
  end
  assign mem_rdata   = sram_word(sa1);
  assign mem_rdata_b = sram_word(sb0);

  // ---------------- driver tasks ----------------
  task automatic idle_a();
    w_req = 1'b0; if_req = 1'b0; w_addr = '0; if_addr = '0;
  endtask

  task automatic pulse_rst_a();
    idle_a();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // Requests asserted while in reset must not be granted.
    w_req = 1'b1; if_req = 1'b1; w_addr = 16'h7; if_addr = 16'h8;
    w_req_b = 1'b1; if_req_b = 1'b1; w_addr_b = 16'h7; if_addr_b = 16'h8;
    @(negedge clk);
    n_checks++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL rst_mem_re got=%b exp=0", mem_re); end
    n_checks++; if ({w_gnt, if_gnt} !== 2'b00) begin n_fail++; $display("FAIL rst_gnt got=%b exp=00", {w_gnt, if_gnt}); end
    n_checks++; if ({w_rvalid, if_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid got=%b exp=00", {w_rvalid, if_rvalid}); end
    n_checks++; if (mem_re_b !== 1'b0) begin n_fail++; $display("FAIL rst_b_mem_re got=%b exp=0", mem_re_b); end
    @(posedge clk); #1;
    rst = 1'b0; rst_b = 1'b0;
    idle_a();
    w_req_b = 1'b0; if_req_b = 1'b0; w_addr_b = '0; if_addr_b = '0;
    @(negedge clk);
    n_checks++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL post_rst_mem_re got=%b exp=0", mem_re); end
    n_checks++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL post_rst_mem_addr got=%h exp=0000", mem_addr); end
    n_checks++; if ({w_rvalid, if_rvalid} !== 2'b00) begin n_fail++; $display("FAIL post_rst_rvalid got=%b exp=00", {w_rvalid, if_rvalid}); end
    n_checks++; if (dbg_owner !== IDLE) begin n_fail++; $display("FAIL post_rst_owner got=%0d exp=%0d", dbg_owner, IDLE); end
    n_checks++; if (dbg_cnt !== 3'd0) begin n_fail++; $display("FAIL post_rst_cnt got=%0d exp=0", dbg_cnt); end
    n_checks++; if ({w_rvalid_b, if_rvalid_b, mem_re_b} !== 3'b000) begin n_fail++; $display("FAIL post_rst_b got=%b exp=000", {w_rvalid_b, if_rvalid_b, mem_re_b}); end
    @(posedge clk); #1;
  endtask

  task automatic test_w_only();
    logic [1:0]  gid  [8];
    logic [15:0] gadr [8];
    logic [1:0]  ev;
    for (int c = 0; c < 8; c++) begin
      w_req = (c < 3); w_addr = 16'h10 + 16'(c); if_req = 1'b0; if_addr = '0;
      gid[c]  = (c < 3) ? 2'd1 : 2'd0;
      gadr[c] = 16'h10 + 16'(c);
      @(negedge clk);
      n_checks++; if (w_gnt !== (c < 3)) begin n_fail++; $display("FAIL wonly_w_gnt c=%0d got=%b exp=%b", c, w_gnt, (c < 3)); end
      n_checks++; if (if_gnt !== 1'b0) begin n_fail++; $display("FAIL wonly_if_gnt c=%0d got=%b exp=0", c, if_gnt); end
      n_checks++; if (mem_addr !== ((c < 3) ? gadr[c] : 16'h0)) begin n_fail++; $display("FAIL wonly_mem_addr c=%0d got=%h", c, mem_addr); end
      ev = (c >= 2) ? gid[c-2] : 2'd0;
      n_checks++; if (w_rvalid !== (ev == 2'd1)) begin n_fail++; $display("FAIL wonly_w_rvalid c=%0d got=%b exp=%b", c, w_rvalid, (ev == 2'd1)); end
      n_checks++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL wonly_if_rvalid c=%0d got=%b exp=0", c, if_rvalid); end
      if (ev == 2'd1) begin
        n_checks++; if (w_rdata !== sram_word(gadr[c-2])) begin n_fail++; $display("FAIL wonly_w_rdata c=%0d got=%h exp=%h", c, w_rdata, sram_word(gadr[c-2])); end
      end
      @(posedge clk); #1;
    end
    idle_a();
  endtask

  task automatic test_both_burst();
    logic [1:0]  gid  [20];
    logic [15:0] gadr [20];
    logic [1:0]  eg, ev;
    int nw, ni;
    nw = 0; ni = 0;
    pulse_rst_a();
    for (int c = 0; c < 20; c++) begin
      w_req = (c < 16); if_req = (c < 16);
      w_addr = 16'h100 + 16'(nw); if_addr = 16'h200 + 16'(ni);
      eg = (c >= 16) ? 2'd0 : (((c / 4) % 2) == 0) ? 2'd1 : 2'd2;
      gid[c]  = eg;
      gadr[c] = (eg == 2'd2) ? if_addr : w_addr;
      @(negedge clk);
      n_checks++; if ({w_gnt, if_gnt} !== {eg == 2'd1, eg == 2'd2}) begin n_fail++; $display("FAIL burst_gnt c=%0d got=%b exp=%b", c, {w_gnt, if_gnt}, {eg == 2'd1, eg == 2'd2}); end
      n_checks++; if (mem_re !== (eg != 2'd0)) begin n_fail++; $display("FAIL burst_mem_re c=%0d got=%b exp=%b", c, mem_re, (eg != 2'd0)); end
      if (eg != 2'd0) begin
        n_checks++; if (mem_addr !== gadr[c]) begin n_fail++; $display("FAIL burst_mem_addr c=%0d got=%h exp=%h", c, mem_addr, gadr[c]); end
      end
      ev = (c >= 2) ? gid[c-2] : 2'd0;
      n_checks++; if ({w_rvalid, if_rvalid} !== {ev == 2'd1, ev == 2'd2}) begin n_fail++; $display("FAIL burst_rvalid c=%0d got=%b exp=%b", c, {w_rvalid, if_rvalid}, {ev == 2'd1, ev == 2'd2}); end
      if (ev == 2'd1) begin
        n_checks++; if (w_rdata !== sram_word(gadr[c-2])) begin n_fail++; $display("FAIL burst_w_rdata c=%0d got=%h exp=%h", c, w_rdata, sram_word(gadr[c-2])); end
      end
      if (ev == 2'd2) begin
        n_checks++; if (if_rdata !== sram_word(gadr[c-2])) begin n_fail++; $display("FAIL burst_if_rdata c=%0d got=%h exp=%h", c, if_rdata, sram_word(gadr[c-2])); end
      end
      if (eg == 2'd1) nw++;
      if (eg == 2'd2) ni++;
      @(posedge clk); #1;
    end
    idle_a();
  endtask

  task automatic test_owner_drop();
    // W owns with burst_cnt=2, then drops; IF must take over the same cycle.
    logic        wq [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        iq [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] wa [8] = '{16'h20, 16'h21, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    logic [15:0] ia [8] = '{16'h30, 16'h30, 16'h30, 16'h31, 16'h0, 16'h0, 16'h0, 16'h0};
    logic [1:0]  gid[8] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [15:0] gadr[8];
    logic [1:0]  ev;
    pulse_rst_a();
    for (int c = 0; c < 8; c++) begin
      w_req = wq[c]; if_req = iq[c]; w_addr = wa[c]; if_addr = ia[c];
      gadr[c] = (gid[c] == 2'd2) ? ia[c] : wa[c];
      @(negedge clk);
      if (c == 2) begin
        n_checks++; if (dbg_cnt !== 3'd2) begin n_fail++; $display("FAIL drop_cnt_before got=%0d exp=2", dbg_cnt); end
        n_checks++; if (dbg_owner !== OWN_W) begin n_fail++; $display("FAIL drop_owner_before got=%0d exp=%0d", dbg_owner, OWN_W); end
      end
      n_checks++; if ({w_gnt, if_gnt} !== {gid[c] == 2'd1, gid[c] == 2'd2}) begin n_fail++; $display("FAIL drop_gnt c=%0d got=%b exp=%b", c, {w_gnt, if_gnt}, {gid[c] == 2'd1, gid[c] == 2'd2}); end
      n_checks++; if (mem_re !== (gid[c] != 2'd0)) begin n_fail++; $display("FAIL drop_mem_re c=%0d got=%b exp=%b", c, mem_re, (gid[c] != 2'd0)); end
      if (gid[c] != 2'd0) begin
        n_checks++; if (mem_addr !== gadr[c]) begin n_fail++; $display("FAIL drop_mem_addr c=%0d got=%h exp=%h", c, mem_addr, gadr[c]); end
      end
      ev = (c >= 2) ? gid[c-2] : 2'd0;
      n_checks++; if ({w_rvalid, if_rvalid} !== {ev == 2'd1, ev == 2'd2}) begin n_fail++; $display("FAIL drop_rvalid c=%0d got=%b exp=%b", c, {w_rvalid, if_rvalid}, {ev == 2'd1, ev == 2'd2}); end
      if (ev == 2'd2) begin
        n_checks++; if (if_rdata !== sram_word(gadr[c-2])) begin n_fail++; $display("FAIL drop_if_rdata c=%0d got=%h exp=%h", c, if_rdata, sram_word(gadr[c-2])); end
      end
      @(posedge clk); #1;
    end
    idle_a();
  endtask

  task automatic test_if_stream();
    logic [2:0] ecnt;
    pulse_rst_a();
    for (int c = 0; c < 22; c++) begin
      w_req = 1'b0; w_addr = '0;
      if_req = (c < 20); if_addr = 16'h300 + 16'(c);
      ecnt = (c == 0) ? 3'd0 : (c >= 4) ? 3'd4 : 3'(c);
      @(negedge clk);
      n_checks++; if ({w_gnt, if_gnt} !== {1'b0, c < 20}) begin n_fail++; $display("FAIL stream_gnt c=%0d got=%b exp=%b", c, {w_gnt, if_gnt}, {1'b0, c < 20}); end
      if (c < 20) begin
        n_checks++; if (mem_addr !== 16'h300 + 16'(c)) begin n_fail++; $display("FAIL stream_mem_addr c=%0d got=%h", c, mem_addr); end
        n_checks++; if (dbg_cnt !== ecnt) begin n_fail++; $display("FAIL stream_cnt c=%0d got=%0d exp=%0d", c, dbg_cnt, ecnt); end
      end
      n_checks++; if ({w_rvalid, if_rvalid} !== {1'b0, c >= 2}) begin n_fail++; $display("FAIL stream_rvalid c=%0d got=%b exp=%b", c, {w_rvalid, if_rvalid}, {1'b0, c >= 2}); end
      if (c >= 2) begin
        n_checks++; if (if_rdata !== sram_word(16'h300 + 16'(c - 2))) begin n_fail++; $display("FAIL stream_if_rdata c=%0d got=%h", c, if_rdata); end
      end
      @(posedge clk); #1;
    end
    idle_a();
  endtask

  task automatic test_reset_mid();
    pulse_rst_a();
    // c0: IF alone, c1: W alone (leaves round-robin pointing at IF).
    if_req = 1'b1; if_addr = 16'h50;
    @(negedge clk);
    n_checks++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_if_gnt got=%b exp=1", if_gnt); end
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = '0; w_req = 1'b1; w_addr = 16'h40;
    @(negedge clk);
    n_checks++; if (w_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_w_gnt got=%b exp=1", w_gnt); end
    @(posedge clk); #1;
    // c2: reset for one cycle while both reads are in flight.
    idle_a();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({w_rvalid, if_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rmid_rvalid_in_rst got=%b exp=00", {w_rvalid, if_rvalid}); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 3; c < 7; c++) begin
      @(negedge clk);
      n_checks++; if ({w_rvalid, if_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rmid_rvalid c=%0d got=%b exp=00", c, {w_rvalid, if_rvalid}); end
      if (c == 3) begin
        n_checks++; if (dbg_owner !== IDLE) begin n_fail++; $display("FAIL rmid_owner got=%0d exp=%0d", dbg_owner, IDLE); end
      end
      @(posedge clk); #1;
    end
    // c7: tie must go to W again.
    w_req = 1'b1; w_addr = 16'h41; if_req = 1'b1; if_addr = 16'h51;
    @(negedge clk);
    n_checks++; if ({w_gnt, if_gnt} !== 2'b10) begin n_fail++; $display("FAIL rmid_tie_gnt got=%b exp=10", {w_gnt, if_gnt}); end
    n_checks++; if (mem_addr !== 16'h41) begin n_fail++; $display("FAIL rmid_tie_addr got=%h exp=0041", mem_addr); end
    @(posedge clk); #1;
    idle_a();
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if ({w_rvalid, if_rvalid} !== 2'b10) begin n_fail++; $display("FAIL rmid_tie_rvalid got=%b exp=10", {w_rvalid, if_rvalid}); end
    n_checks++; if (w_rdata !== sram_word(16'h41)) begin n_fail++; $display("FAIL rmid_tie_rdata got=%h exp=%h", w_rdata, sram_word(16'h41)); end
    @(posedge clk); #1;
  endtask

  task automatic test_lat1_alternate();
    logic [1:0]  gid  [10];
    logic [15:0] gadr [10];
    logic [1:0]  eg, ev;
    int nw, ni;
    nw = 0; ni = 0;
    for (int c = 0; c < 10; c++) begin
      w_req_b = (c < 8); if_req_b = (c < 8);
      w_addr_b = 16'h500 + 16'(nw); if_addr_b = 16'h600 + 16'(ni);
      eg = (c >= 8) ? 2'd0 : ((c % 2) == 0) ? 2'd1 : 2'd2;
      gid[c]  = eg;
      gadr[c] = (eg == 2'd2) ? if_addr_b : w_addr_b;
      @(negedge clk);
      n_checks++; if ({w_gnt_b, if_gnt_b} !== {eg == 2'd1, eg == 2'd2}) begin n_fail++; $display("FAIL alt_gnt c=%0d got=%b exp=%b", c, {w_gnt_b, if_gnt_b}, {eg == 2'd1, eg == 2'd2}); end
      if (eg != 2'd0) begin
        n_checks++; if (mem_addr_b !== gadr[c]) begin n_fail++; $display("FAIL alt_mem_addr c=%0d got=%h exp=%h", c, mem_addr_b, gadr[c]); end
      end
      ev = (c >= 1) ? gid[c-1] : 2'd0;
      n_checks++; if ({w_rvalid_b, if_rvalid_b} !== {ev == 2'd1, ev == 2'd2}) begin n_fail++; $display("FAIL alt_rvalid c=%0d got=%b exp=%b", c, {w_rvalid_b, if_rvalid_b}, {ev == 2'd1, ev == 2'd2}); end
      if (ev == 2'd1) begin
        n_checks++; if (w_rdata_b !== sram_word(gadr[c-1])) begin n_fail++; $display("FAIL alt_w_rdata c=%0d got=%h exp=%h", c, w_rdata_b, sram_word(gadr[c-1])); end
      end
      if (ev == 2'd2) begin
        n_checks++; if (if_rdata_b !== sram_word(gadr[c-1])) begin n_fail++; $display("FAIL alt_if_rdata c=%0d got=%h exp=%h", c, if_rdata_b, sram_word(gadr[c-1])); end
      end
      if (eg == 2'd1) nw++;
      if (eg == 2'd2) ni++;
      @(posedge clk); #1;
    end
    w_req_b = 1'b0; if_req_b = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; rst_b = 1'b1;
    idle_a();
    w_req_b = 1'b0; if_req_b = 1'b0; w_addr_b = '0; if_addr_b = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_w_only();
    test_both_burst();
    test_owner_drop();
    test_if_stream();
    test_reset_mid();
    test_lat1_alternate();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
